// File: rtl/lsu_align.sv
// Load/store alignment between the MEM stage and dmem: aligned accesses pass straight through,
// misaligned ones are split (or trapped when LSU_MISALIGN_TRAP_EN is defined).
module lsu_align #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            misalign_exc,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    output logic [1:0]      mem_be,
    input  logic [XLEN-1:0] mem_rd
);

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic {IDLE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTES} state_t;
`endif

    state_t          state;
    logic            active;
    logic            aligned;
    logic            misaligned;
    logic [XLEN-1:0] base;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [1:0] size,
                                               input logic uns);
        case (size)
            2'b00:   return uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   return uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign active = req_valid && (req_size != 2'b11);
    assign base   = {req_addr[XLEN-1:2], 2'b00};

    always_comb begin
        case (req_size)
            2'b01:   aligned = (req_addr[1:0] != 2'b11);
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign misaligned = active && !aligned;

`ifndef LSU_MISALIGN_TRAP_EN
    logic [1:0]        cnt;
    logic [1:0]        last_idx;
    logic [XLEN-1:0]   lo_word;
    logic [2*XLEN-1:0] joined;
    logic [XLEN-1:0]   wshift;

    assign last_idx = (req_size == 2'b10) ? 2'd3 : 2'd1;
    assign joined   = {mem_rd, lo_word} >> {req_addr[1:0], 3'b000};
    assign wshift   = req_wdata >> {cnt, 3'b000};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
`ifndef LSU_MISALIGN_TRAP_EN
            cnt     <= '0;
            lo_word <= '0;
`endif
        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            state <= IDLE;
`else
            case (state)
                IDLE: begin
                    if (misaligned) begin
                        if (req_we) begin
                            state <= ST_BYTES;
                            cnt   <= 2'd1;
                        end else begin
                            lo_word <= mem_rd;
                            state   <= LD_HI;
                        end
                    end
                end
                LD_HI: state <= IDLE;
                ST_BYTES: begin
                    // a dropped request aborts; bytes already stored stay in dmem
                    if (!req_valid || cnt == last_idx) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

    always_comb begin
        stall        = 1'b0;
        load_data    = '0;
        misalign_exc = 1'b0;
        mem_we       = 1'b0;
        mem_a        = '0;
        mem_wd       = '0;
        mem_be       = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (active && aligned) begin
                        mem_a  = req_addr;
                        mem_wd = req_wdata;
                        mem_be = req_size;
                        mem_we = req_we;
                        if (!req_we)
                            load_data = extend(mem_rd >> {req_addr[1:0], 3'b000}, req_size,
                                               req_unsigned);
                    end else if (misaligned) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_exc = 1'b1;
`else
                        stall = 1'b1;
                        if (req_we) begin
                            mem_a  = req_addr;
                            mem_we = 1'b1;
                            mem_wd = {24'b0, req_wdata[7:0]};
                        end else begin
                            mem_a  = base;
                            mem_be = 2'b10;
                        end
`endif
                    end
                end
`ifndef LSU_MISALIGN_TRAP_EN
                LD_HI: begin
                    if (req_valid) begin
                        mem_a     = base + XLEN'(4);
                        mem_be    = 2'b10;
                        load_data = extend(joined[XLEN-1:0], req_size, req_unsigned);
                    end
                end
                ST_BYTES: begin
                    if (req_valid) begin
                        mem_a  = req_addr + XLEN'(cnt);
                        mem_we = 1'b1;
                        mem_wd = {24'b0, wshift[7:0]};
                        stall  = (cnt != last_idx);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: byte-array reference memory, directed and random requests.
module tb_lsu_align;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign_exc;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [1:0]  mem_be;
    logic [31:0] mem_rd;

    logic [31:0] dmem     [0:15];
    logic [31:0] init_val [0:15];
    logic        init_mem = 1'b0;
    logic [7:0]  ref_mem  [0:63];
    logic [31:0] last_ld;
    int          checks = 0;
    int          failures = 0;

    lsu_align #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned), .stall(stall),
        .load_data(load_data), .misalign_exc(misalign_exc), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_be(mem_be), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = dmem[mem_a[5:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) dmem[i] <= init_val[i];
        end else if (mem_we) begin
            case (mem_be)
                2'b00:   dmem[mem_a[5:2]][8*mem_a[1:0] +: 8]  <= mem_wd[7:0];
                2'b01:   dmem[mem_a[5:2]][8*mem_a[1:0] +: 16] <= mem_wd[15:0];
                default: dmem[mem_a[5:2]] <= mem_wd;
            endcase
        end
    end

    function automatic logic [31:0] ref_word(input int unsigned a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    function automatic logic [31:0] ref_load(input int unsigned a, input logic [1:0] size,
                                             input logic uns);
        logic [31:0] v = ref_word(a);
        if (size == 2'd0) begin
            v &= 32'hFF;
            if (!uns && v[7]) v |= 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v &= 32'hFFFF;
            if (!uns && v[15]) v |= 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic bit is_aligned(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd0) || (size == 2'd1 && a[1:0] != 2'b11) || (size == 2'd2 && a[1:0] == 2'b00);
    endfunction

    function automatic logic [7:0] dmem_byte(input int unsigned a);
        logic [31:0] w = dmem[a/4];
        return 8'(w >> (8*(a%4)));
    endfunction

    task automatic preload();
        init_val[0] = 32'h4433_2211;
        init_val[1] = 32'h8877_6655;
        init_val[2] = 32'hCCBB_AA99;
        for (int i = 3; i < 16; i++) init_val[i] = $urandom;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(init_val[i] >> (8*b));
        init_mem = 1'b1;
        @(posedge clk); #1;
        init_mem = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        bit          al = is_aligned(size, addr);
        int unsigned nb = 1 << size;
        int unsigned n = al ? 1 : (we ? nb : 2);
        logic [31:0] base = addr & ~32'h3;
        logic [31:0] exp_a, exp_wd, exp_ld;
        logic        exp_stall;
        exp_ld = we ? 32'h0 : ref_load(addr, size, uns);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            exp_stall = (i + 1 < n);
            exp_a  = al ? addr : (we ? addr + i : base + 4*i);
            exp_wd = al ? wdata : ((wdata >> (8*i)) & 32'hFF);
            checks++;
            if (stall !== exp_stall) begin
                failures++;
                $display("FAIL %s stall cyc%0d got=%0b exp=%0b", tag, i, stall, exp_stall);
            end
            checks++;
            if (mem_we !== we) begin
                failures++;
                $display("FAIL %s mem_we cyc%0d got=%0b exp=%0b", tag, i, mem_we, we);
            end
            if (al || !we || i + 1 < n || 1'b1) begin
                checks++;
                if (mem_a !== exp_a) begin
                    failures++;
                    $display("FAIL %s mem_a cyc%0d got=%h exp=%h", tag, i, mem_a, exp_a);
                end
            end
            if (we) begin
                checks++;
                if (mem_wd !== exp_wd || mem_be !== (al ? size : 2'b00)) begin
                    failures++;
                    $display("FAIL %s mem_wd/be cyc%0d got=%h/%b exp=%h/%b", tag, i, mem_wd,
                             mem_be, exp_wd, al ? size : 2'b00);
                end
            end else if (al) begin
                checks++;
                if (mem_be !== size) begin
                    failures++;
                    $display("FAIL %s mem_be got=%b exp=%b", tag, mem_be, size);
                end
            end
            checks++;
            if (misalign_exc !== 1'b0) begin
                failures++;
                $display("FAIL %s misalign_exc got=%0b exp=0", tag, misalign_exc);
            end
            if (!exp_stall) begin
                last_ld = load_data;
                checks++;
                if (load_data !== exp_ld) begin
                    failures++;
                    $display("FAIL %s load_data got=%h exp=%h", tag, load_data, exp_ld);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (we)
            for (int unsigned b = 0; b < nb; b++) ref_mem[addr+b] = 8'(wdata >> (8*b));
        for (int unsigned b = 0; b < 4; b++) begin
            checks++;
            if (dmem_byte(addr + b) !== ref_mem[addr+b]) begin
                failures++;
                $display("FAIL %s mem[%h] got=%h exp=%h", tag, addr + b, dmem_byte(addr + b),
                         ref_mem[addr+b]);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1; req_wdata = 32'hDEAD_BEEF;
        req_size = 2'b10;
        #1;
        checks++;
        if ({stall, mem_we, mem_be, mem_a, mem_wd, load_data, misalign_exc} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got stall=%0b we=%0b be=%b a=%h wd=%h ld=%h exc=%0b exp=all0",
                     stall, mem_we, mem_be, mem_a, mem_wd, load_data, misalign_exc);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        preload();
        run_req("lb3", 1'b0, 32'h03, '0, 2'd0, 1'b0);
        checks++;
        if (last_ld !== 32'h0000_0044) begin failures++; $display("FAIL lb3_const got=%h exp=00000044", last_ld); end
        run_req("lb7", 1'b0, 32'h07, '0, 2'd0, 1'b0);
        checks++;
        if (last_ld !== 32'hFFFF_FF88) begin failures++; $display("FAIL lb7_const got=%h exp=ffffff88", last_ld); end
        run_req("lbu7", 1'b0, 32'h07, '0, 2'd0, 1'b1);
        checks++;
        if (last_ld !== 32'h0000_0088) begin failures++; $display("FAIL lbu7_const got=%h exp=00000088", last_ld); end
        run_req("lh3", 1'b0, 32'h03, '0, 2'd1, 1'b0);
        checks++;
        if (last_ld !== 32'h0000_5544) begin failures++; $display("FAIL lh3_const got=%h exp=00005544", last_ld); end
        run_req("lw6", 1'b0, 32'h06, '0, 2'd2, 1'b0);
        checks++;
        if (last_ld !== 32'hAA99_8877) begin failures++; $display("FAIL lw6_const got=%h exp=aa998877", last_ld); end
        run_req("sw1", 1'b1, 32'h01, 32'hDEAD_BEEF, 2'd2, 1'b0);
        checks++;
        if (dmem[0] !== 32'hADBE_EF11 || dmem[1] !== 32'h8877_66DE) begin
            failures++;
            $display("FAIL sw1_readback got=%h/%h exp=adbeef11/887766de", dmem[0], dmem[1]);
        end
        run_req("sh3", 1'b1, 32'h03, 32'h0000_CAFE, 2'd1, 1'b0);
        checks++;
        if (dmem[0] !== 32'hFEBE_EF11 || dmem[1] !== 32'h8877_66CA) begin
            failures++;
            $display("FAIL sh3_readback got=%h/%h exp=febeef11/887766ca", dmem[0], dmem[1]);
        end
        run_req("sh2", 1'b1, 32'h02, 32'h0000_1234, 2'd1, 1'b0);
        checks++;
        if (dmem[0] !== 32'h1234_EF11) begin failures++; $display("FAIL sh2_readback got=%h exp=1234ef11", dmem[0]); end
    endtask

    task automatic test_idle_and_noop();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_we !== 1'b0 || load_data !== '0) begin
            failures++;
            $display("FAIL idle got stall=%0b we=%0b ld=%h exp=0/0/0", stall, mem_we, load_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h09; req_wdata = 32'h5A5A_5A5A; req_size = 2'b11;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL size11 got stall=%0b we=%0b exp=0/0", stall, mem_we);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (dmem[2] !== ref_word(8)) begin failures++; $display("FAIL size11_mem got=%h exp=%h", dmem[2], ref_word(8)); end
    endtask

    task automatic test_abort();
        preload();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h03; req_wdata = 32'h0000_CAFE; req_size = 2'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL abort_cycle got we=%0b stall=%0b exp=0/0", mem_we, stall);
        end
        @(posedge clk); #1;
        ref_mem[3] = 8'hFE;
        run_req("after_abort", 1'b0, 32'h02, '0, 2'd2, 1'b0);
    endtask

    task automatic test_reset_mid();
        preload();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h06; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_ldhi got stall=%0b we=%0b exp=0/0", stall, mem_we);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        run_req("after_rst_ld", 1'b0, 32'h07, '0, 2'd0, 1'b0);

        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h01; req_wdata = 32'hDEAD_BEEF; req_size = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_st got stall=%0b we=%0b exp=0/0", stall, mem_we);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        ref_mem[1] = 8'hEF; ref_mem[2] = 8'hBE;
        checks++;
        if (dmem[0] !== 32'h44BE_EF11 || dmem[1] !== 32'h8877_6655) begin
            failures++;
            $display("FAIL rst_st_mem got=%h/%h exp=44beef11/88776655", dmem[0], dmem[1]);
        end
        run_req("after_rst_st", 1'b0, 32'h00, '0, 2'd2, 1'b0);
    endtask

    task automatic test_random();
        preload();
        for (int t = 0; t < 150; t++)
            run_req("rand", 1'($urandom), $urandom_range(0, 56), $urandom,
                    2'($urandom_range(0, 2)), 1'($urandom));
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_trap();
        preload();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h02; req_size = 2'd2;
        @(negedge clk);
        checks++;
        if (misalign_exc !== 1'b1 || mem_we !== 1'b0 || stall !== 1'b0 || load_data !== '0) begin
            failures++;
            $display("FAIL trap_lw2 got exc=%0b we=%0b stall=%0b ld=%h exp=1/0/0/0", misalign_exc,
                     mem_we, stall, load_data);
        end
        @(posedge clk); #1;
        req_addr = 32'h00;
        @(negedge clk);
        checks++;
        if (misalign_exc !== 1'b0 || load_data !== 32'h4433_2211) begin
            failures++;
            $display("FAIL trap_lw0 got exc=%0b ld=%h exp=0/44332211", misalign_exc, load_data);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef LSU_MISALIGN_TRAP_EN
        test_trap();
`else
        test_directed();
        test_idle_and_noop();
        test_abort();
        test_reset_mid();
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
